// File: rtl/div_seq_ctrl.sv
// Sequential restoring divider: one trial subtraction per clock through a single WIDTH-bit subtractor.
// Optional macro SIGNED_DIV_EN adds a signed_op input for truncating signed division.
module div_seq_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef SIGNED_DIV_EN
   input  logic             signed_op,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero,
   output logic             zero_flag
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dz_q, dz_d;
   logic             zf_q, zf_d;

   logic [WIDTH-1:0] a_in, b_in;
   logic [WIDTH-1:0] fin_quo, fin_rem;

`ifdef SIGNED_DIV_EN
   logic qneg_q, qneg_d;
   logic rneg_q, rneg_d;
   logic a_neg, b_neg;

   // Operands become magnitudes at capture; signs are reapplied once the loop finishes.
   assign a_neg   = signed_op & a[WIDTH-1];
   assign b_neg   = signed_op & b[WIDTH-1];
   assign a_in    = a_neg ? (~a + 1'b1) : a;
   assign b_in    = b_neg ? (~b + 1'b1) : b;
   assign fin_quo = qneg_q ? (~q_q + 1'b1) : q_q;
   assign fin_rem = rneg_q ? (~r_q + 1'b1) : r_q;
`else
   assign a_in    = a;
   assign b_in    = b;
   assign fin_quo = q_q;
   assign fin_rem = r_q;
`endif

   // Shifted partial remainder keeps the bit shifted out of R as a 33rd bit.
   logic [WIDTH:0]   s_w;
   logic [WIDTH-1:0] diff_w;
   logic             borrow_w, take_w;

   assign s_w                = {r_q, q_q[WIDTH-1]};
   assign {borrow_w, diff_w} = {1'b0, s_w[WIDTH-1:0]} - {1'b0, dvs_q};
   assign take_w             = s_w[WIDTH] | ~borrow_w;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvs_d   = dvs_q;
      q_d     = q_q;
      r_d     = r_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dz_d    = dz_q;
      zf_d    = zf_q;
`ifdef SIGNED_DIV_EN
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (b == '0) begin
                  quo_d   = '1;
                  rem_d   = a;
                  dz_d    = 1'b1;
                  zf_d    = 1'b0;
                  state_d = S_DONE;
               end else begin
                  dvs_d   = b_in;
                  q_d     = a_in;
                  r_d     = '0;
                  cnt_d   = '0;
`ifdef SIGNED_DIV_EN
                  qneg_d  = a_neg ^ b_neg;
                  rneg_d  = a_neg;
`endif
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            q_d   = {q_q[WIDTH-2:0], take_w};
            r_d   = take_w ? diff_w : s_w[WIDTH-1:0];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1))
               state_d = S_FIN;
         end
         S_FIN: begin
            quo_d   = fin_quo;
            rem_d   = fin_rem;
            dz_d    = 1'b0;
            zf_d    = (fin_quo == '0);
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         dvs_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
         zf_q    <= 1'b0;
`ifdef SIGNED_DIV_EN
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvs_q   <= dvs_d;
         q_q     <= q_d;
         r_q     <= r_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
         zf_q    <= zf_d;
`ifdef SIGNED_DIV_EN
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
`endif
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign div_zero  = dz_q;
   assign zero_flag = zf_q;

endmodule
